// File: rtl/dmem_bus_bridge_pkg.sv
// Shared state encodings and constants for the data-memory bus bridge.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam logic [31:0] ZERO_WORD       = '0;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter for REQ; o_expired marks the last permitted bus cycle.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = dmem_bus_bridge_pkg::DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned    CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns single-cycle MEM-stage data strobes into a held req/ack bus transaction,
// stalling the pipeline until the access completes or times out.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = dmem_bus_bridge_pkg::DEFAULT_TIMEOUT
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [3:0]  dre,
  input  logic [31:0] din,
  output logic        stall_req,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  import dmem_bus_bridge_pkg::*;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_err;

  logic w_expired;
  logic w_ctr_clr;
  logic w_ctr_en;
  logic w_unused_addr_lsb;

  assign w_ctr_clr         = (r_state == ST_IDLE);
  assign w_ctr_en          = (r_state == ST_REQ) && !bus_ack;
  assign w_unused_addr_lsb = ^daddr[1:0];

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .i_clk     (cpu_clk_50M),
    .i_rst_n   (cpu_rst_n),
    .i_clr     (w_ctr_clr),
    .i_en      (w_ctr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= ZERO_WORD;
      r_be          <= '0;
      r_wr          <= 1'b0;
      r_wdata       <= ZERO_WORD;
      r_rdata       <= ZERO_WORD;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (dce) begin
            r_addr  <= {daddr[31:2], 2'b00};
            r_be    <= we | dre;
            r_wr    <= |we;
            r_wdata <= din;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack in the final permitted cycle wins over the timeout.
          if (bus_ack) begin
            if (!r_wr) begin
              r_rdata       <= bus_rdata;
              r_rdata_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the async-reset state register so reset drops the request immediately.
  assign bus_req     = (r_state == ST_REQ);
  assign stall_req   = (r_state == ST_REQ) || ((r_state == ST_IDLE) && dce);
  assign bus_wr      = r_wr;
  assign bus_addr    = r_addr;
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign bus_err     = r_err;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench: two bridge instances (TIMEOUT 8 and 4) driven by directed transactions.
module tb_dmem_bus_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        valid;
    logic        err;
    int          ncyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dce [2];
  logic        ack [2];
  logic [31:0] daddr, din, bus_rdata;
  logic [3:0]  we, dre;

  logic        o_stall  [2];
  logic [31:0] o_rdata  [2];
  logic        o_rvalid [2];
  logic        o_err    [2];
  logic        o_req    [2];
  logic        o_wr     [2];
  logic [31:0] o_addr   [2];
  logic [3:0]  o_be     [2];
  logic [31:0] o_wdata  [2];

  int n_checks = 0;
  int n_errors = 0;
  int to_cyc [2] = '{8, 4};
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT(8)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .dce(dce[0]), .daddr(daddr), .we(we), .dre(dre),
    .din(din), .stall_req(o_stall[0]), .rdata(o_rdata[0]), .rdata_valid(o_rvalid[0]),
    .bus_err(o_err[0]), .bus_req(o_req[0]), .bus_wr(o_wr[0]), .bus_addr(o_addr[0]),
    .bus_be(o_be[0]), .bus_wdata(o_wdata[0]), .bus_ack(ack[0]), .bus_rdata(bus_rdata)
  );

  dmem_bus_bridge #(.TIMEOUT(4)) dut4 (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .dce(dce[1]), .daddr(daddr), .we(we), .dre(dre),
    .din(din), .stall_req(o_stall[1]), .rdata(o_rdata[1]), .rdata_valid(o_rvalid[1]),
    .bus_err(o_err[1]), .bus_req(o_req[1]), .bus_wr(o_wr[1]), .bus_addr(o_addr[1]),
    .bus_be(o_be[1]), .bus_wdata(o_wdata[1]), .bus_ack(ack[1]), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: checks request fields at the rising edge of bus_req and the
  // completion status in the DONE cycle (first sample with bus_req low again).
  logic prev_req [2] = '{1'b0, 1'b0};
  int   reqcnt   [2] = '{0, 0};
  int   stcnt    [2] = '{0, 0};

  always @(negedge clk) begin
    exp_t e;
    string p;
    for (int d = 0; d < 2; d++) begin
      p = $sformatf("d%0d_", d);
      if (!rst_n) begin
        prev_req[d] = 1'b0;
        reqcnt[d]   = 0;
        stcnt[d]    = 0;
      end else begin
        if (o_stall[d]) stcnt[d]++;
        if (o_req[d] && !prev_req[d]) begin
          reqcnt[d] = 1;
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk({p, "unexpected_req"}, 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? q0[0] : q1[0];
            chk({p, "bus_addr"},  o_addr[d],  e.addr);
            chk({p, "bus_be"},    {28'd0, o_be[d]}, {28'd0, e.be});
            chk({p, "bus_wr"},    {31'd0, o_wr[d]}, {31'd0, e.wr});
            chk({p, "bus_wdata"}, o_wdata[d], e.wdata);
          end
        end else if (o_req[d]) begin
          reqcnt[d]++;
        end else if (prev_req[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) != 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk({p, "req_cycles"},   reqcnt[d], e.ncyc);
            chk({p, "stall_cycles"}, stcnt[d],  e.ncyc + 1);
            chk({p, "done_stall"},   {31'd0, o_stall[d]},  32'd0);
            chk({p, "rdata_valid"},  {31'd0, o_rvalid[d]}, {31'd0, e.valid});
            chk({p, "rdata"},        o_rdata[d], e.rdata);
            chk({p, "bus_err"},      {31'd0, o_err[d]},    {31'd0, e.err});
          end
          stcnt[d] = 0;
        end else if (o_rvalid[d]) begin
          chk({p, "spurious_rdata_valid"}, 32'd1, 32'd0);
        end
        prev_req[d] = o_req[d];
      end
    end
  end

  task automatic push_exp(input int d, input logic [31:0] a, input logic [3:0] w,
                          input logic [3:0] r, input logic [31:0] data,
                          input logic [31:0] rdv, input int n);
    exp_t e;
    e.addr  = {a[31:2], 2'b00};
    e.be    = w | r;
    e.wr    = |w;
    e.wdata = data;
    e.ncyc  = (n == 0) ? to_cyc[d] : n;
    if (!e.wr && n > 0) m_rdata[d] = rdv;
    if (n == 0) m_err[d] = 1'b1;
    e.rdata = m_rdata[d];
    e.valid = !e.wr && (n > 0);
    e.err   = m_err[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Called at #1 after an edge with the DUT in IDLE; returns at #1 after the
  // edge following DONE. n = REQ cycle carrying the ack, 0 = never ack.
  task automatic issue(input int d, input logic [31:0] a, input logic [3:0] w,
                       input logic [3:0] r, input logic [31:0] data,
                       input logic [31:0] rdv, input int n);
    int cyc;
    push_exp(d, a, w, r, data, rdv, n);
    daddr = a; we = w; dre = r; din = data; dce[d] = 1'b1;
    @(posedge clk) #1;
    cyc = 0;
    while (o_req[d] && cyc < 40) begin
      cyc++;
      if (cyc == n) begin ack[d] = 1'b1; bus_rdata = rdv; end
      @(posedge clk) #1;
      ack[d] = 1'b0;
      bus_rdata = 32'hBAD0_BAD0;
    end
    if (cyc >= 40) begin
      n_checks++; n_errors++;
      $display("FAIL txn_bound: bus_req still high after %0d cycles, expected release", cyc);
    end
    @(posedge clk) #1;
    dce[d] = 1'b0; we = '0; dre = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    dce = '{1'b0, 1'b0}; ack = '{1'b0, 1'b0};
    daddr = '0; din = '0; we = '0; dre = '0; bus_rdata = 32'hBAD0_BAD0;
    m_rdata = '{32'd0, 32'd0}; m_err = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk) #1;

    chk("reset_bus_req",   {31'd0, o_req[0]},    32'd0);
    chk("reset_stall",     {31'd0, o_stall[0]},  32'd0);
    chk("reset_rvalid",    {31'd0, o_rvalid[0]}, 32'd0);
    chk("reset_err",       {31'd0, o_err[0]},    32'd0);
    chk("reset_bus_addr",  o_addr[0],  32'd0);
    chk("reset_rdata",     o_rdata[0], 32'd0);

    // Main instance, TIMEOUT = 8
    issue(0, 32'h0000_1006, 4'h0, 4'hF, 32'h0, 32'hA1B2_C3D4, 1);
    issue(0, 32'h0000_2000, 4'b0010, 4'h0, 32'h0000_00EE, 32'hDEAD_BEEF, 5);
    issue(0, 32'h0000_3008, 4'h0, 4'b1100, 32'h0, 32'h1122_3344, 1);
    issue(0, 32'h0000_300C, 4'hF, 4'h0, 32'h5566_7788, 32'hDEAD_BEEF, 1);
    issue(0, 32'h0000_0401, 4'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 2);
    issue(0, 32'h0000_0500, 4'h0, 4'b0001, 32'h0, 32'h0102_0304, 8);

    // Short-timeout instance, TIMEOUT = 4
    issue(1, 32'h0000_7000, 4'h0, 4'hF, 32'h0, 32'h7777_0000, 4);
    issue(1, 32'h0000_7004, 4'h0, 4'hF, 32'h0, 32'h8888_0000, 0);
    @(posedge clk) #1;
    chk("d1_err_sticky_idle", {31'd0, o_err[1]}, 32'd1);
    issue(1, 32'h0000_7008, 4'h0, 4'hF, 32'h0, 32'h9999_0000, 2);

    // Reset in the middle of REQ, then a stray ack
    push_exp(0, 32'h0000_5000, 4'h0, 4'hF, 32'h0, 32'h0, 1);
    daddr = 32'h0000_5000; dre = 4'hF; dce[0] = 1'b1;
    @(posedge clk) #1;
    chk("rst_pre_req", {31'd0, o_req[0]}, 32'd1);
    #2 rst_n = 1'b0; dce[0] = 1'b0; dre = '0;
    #1;
    chk("rst_bus_req",   {31'd0, o_req[0]},    32'd0);
    chk("rst_stall",     {31'd0, o_stall[0]},  32'd0);
    chk("rst_rvalid",    {31'd0, o_rvalid[0]}, 32'd0);
    chk("rst_bus_wr",    {31'd0, o_wr[0]},     32'd0);
    chk("rst_bus_addr",  o_addr[0],  32'd0);
    chk("rst_bus_be",    {28'd0, o_be[0]}, 32'd0);
    chk("rst_bus_wdata", o_wdata[0], 32'd0);
    chk("rst_rdata",     o_rdata[0], 32'd0);
    chk("rst_d1_err",    {31'd0, o_err[1]}, 32'd0);
    q0.delete();
    m_rdata = '{32'd0, 32'd0}; m_err = '{1'b0, 1'b0};
    @(posedge clk) #1 rst_n = 1'b1;
    ack[0] = 1'b1; bus_rdata = 32'h9999_9999;
    @(posedge clk) #1;
    ack[0] = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    chk("late_ack_req",    {31'd0, o_req[0]},    32'd0);
    chk("late_ack_rvalid", {31'd0, o_rvalid[0]}, 32'd0);
    chk("late_ack_rdata",  o_rdata[0], 32'd0);
    @(posedge clk) #1;
    chk("late_ack_stall",  {31'd0, o_stall[0]},  32'd0);
    issue(0, 32'h0000_6000, 4'h0, 4'hF, 32'h0, 32'h0BAD_F00D, 1);

    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
